// File: rtl/rgb_linebuf_pingpong_pkg.sv
// Shared video package: write-FSM encodings, default geometry and the bank-index wrap helper
// used by the RGB ping-pong line buffer.
package rgb_linebuf_pingpong_pkg;

    localparam int DEF_CH     = 3;
    localparam int DEF_DW     = 8;
    localparam int DEF_AW     = 12;
    localparam int DEF_LINE_W = 1920;
    localparam int DEF_NBANK  = 3;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_FILL  = 2'd1,
        W_BLOCK = 2'd2
    } wr_state_e;

    // Operands never exceed 2*n-1, so one conditional subtract is a full modulo.
    function automatic int wrap_idx(input int idx, input int n);
        return (idx >= n) ? (idx - n) : idx;
    endfunction

endpackage

// File: rtl/rgb_linebuf_pingpong_bram.sv
// Single-channel line RAM: one write port, two read ports with registered outputs.
// Read-during-write to the same address returns the old contents.
module bram_asymmetric_r2_w1_port #(
    parameter int C_ADDR_WIDTH = 12,
    parameter int C_DATA_WIDTH = 8
) (
    input  logic                    wclk,
    input  logic                    we,
    input  logic [C_ADDR_WIDTH-1:0] waddr,
    input  logic [C_DATA_WIDTH-1:0] wdata,
    input  logic                    rclk,
    input  logic                    re,
    input  logic [C_ADDR_WIDTH-1:0] raddr0,
    input  logic [C_ADDR_WIDTH-1:0] raddr1,
    output logic [C_DATA_WIDTH-1:0] rdata0,
    output logic [C_DATA_WIDTH-1:0] rdata1
);

    logic [C_DATA_WIDTH-1:0] mem [2**C_ADDR_WIDTH];
    logic [C_DATA_WIDTH-1:0] rdata0_q;
    logic [C_DATA_WIDTH-1:0] rdata1_q;

    always_ff @(posedge wclk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge rclk) begin
        if (re) begin
            rdata0_q <= mem[raddr0];
            rdata1_q <= mem[raddr1];
        end
    end

    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;

endmodule

// File: rtl/rgb_linebuf_pingpong.sv
// Multi-bank RGB line buffer: the writer fills lines into a ring of banks, the reader
// fetches two taps from the oldest two complete lines and releases lines when done.
module rgb_linebuf_pingpong
    import rgb_linebuf_pingpong_pkg::*;
#(
    parameter int CH     = DEF_CH,
    parameter int DW     = DEF_DW,
    parameter int AW     = DEF_AW,
    parameter int LINE_W = DEF_LINE_W,
    parameter int NBANK  = DEF_NBANK
) (
    input  logic                         clk_in,
    input  logic                         rst_n,
    input  logic                         wr_sof,
    input  logic                         wr_vld,
    input  logic [CH*DW-1:0]             wr_data,
    output logic                         wr_rdy,
    input  logic                         rd_req,
    input  logic [AW-1:0]                rd_addr0,
    input  logic [AW-1:0]                rd_addr1,
    input  logic                         rd_line_adv,
    output logic [CH*DW-1:0]             rd_top0,
    output logic [CH*DW-1:0]             rd_top1,
    output logic [CH*DW-1:0]             rd_bot0,
    output logic [CH*DW-1:0]             rd_bot1,
    output logic                         rd_vld,
    output logic [$clog2(NBANK+1)-1:0]   lines_avail,
    output logic                         line_done,
    output logic                         ovf
);

    localparam int BW = $clog2(NBANK);
    localparam int LW = $clog2(NBANK+1);
    localparam int PW = CH*DW;

    wr_state_e       state_q, state_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [BW-1:0]   oldest_q, oldest_d;
    logic [LW-1:0]   avail_q, avail_d;
    logic            line_done_q, line_done_d;
    logic            ovf_q, ovf_d;
    logic            rd_vld_q, rd_vld_d;
    logic            data_ok_q, data_ok_d;
    logic [BW-1:0]   top_sel_q, top_sel_d;
    logic [BW-1:0]   bot_sel_q, bot_sel_d;

    logic            wr_acc, line_cmp, adv_ok, rd_acc, we_any;
    logic [BW-1:0]   wr_bank, we_bank;
    logic [AW-1:0]   we_addr;

    logic [NBANK-1:0][PW-1:0] bank_rd0;
    logic [NBANK-1:0][PW-1:0] bank_rd1;
    logic [PW-1:0]   top0, top1, bot0, bot1;

    assign wr_rdy = (avail_q < LW'(NBANK));

    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        oldest_d    = oldest_q;
        avail_d     = avail_q;
        line_done_d = 1'b0;
        ovf_d       = ovf_q;
        rd_vld_d    = 1'b0;
        data_ok_d   = data_ok_q;
        top_sel_d   = top_sel_q;
        bot_sel_d   = bot_sel_q;
        wr_acc      = 1'b0;
        line_cmp    = 1'b0;
        adv_ok      = 1'b0;
        rd_acc      = 1'b0;
        wr_bank     = BW'(wrap_idx(int'(oldest_q) + int'(avail_q), NBANK));
        we_any      = 1'b0;
        we_bank     = wr_bank;
        we_addr     = wr_addr_q;

        if (wr_sof) begin
            // Frame start wins over everything; a coincident pixel opens the new frame.
            wr_addr_d = '0;
            oldest_d  = '0;
            avail_d   = '0;
            ovf_d     = 1'b0;
            state_d   = W_IDLE;
            if (wr_vld) begin
                we_any    = 1'b1;
                we_bank   = '0;
                we_addr   = '0;
                wr_addr_d = AW'(1);
                state_d   = W_FILL;
            end
        end else begin
            wr_acc   = wr_vld && wr_rdy;
            adv_ok   = rd_line_adv && (avail_q != '0);
            rd_acc   = rd_req && (avail_q >= LW'(2));
            line_cmp = wr_acc && (wr_addr_q == AW'(LINE_W-1));
            we_any   = wr_acc;

            if (wr_vld && !wr_rdy) begin
                ovf_d = 1'b1;
            end
            if (wr_acc) begin
                wr_addr_d = line_cmp ? '0 : (wr_addr_q + 1'b1);
            end
            line_done_d = line_cmp;

            if (line_cmp && !adv_ok) begin
                avail_d = avail_q + 1'b1;
            end else if (!line_cmp && adv_ok) begin
                avail_d = avail_q - 1'b1;
            end
            if (adv_ok) begin
                oldest_d = BW'(wrap_idx(int'(oldest_q) + 1, NBANK));
            end

            // Bank choice is captured now so a same-cycle release cannot redirect the read.
            if (rd_acc) begin
                rd_vld_d  = 1'b1;
                data_ok_d = 1'b1;
                top_sel_d = oldest_q;
                bot_sel_d = BW'(wrap_idx(int'(oldest_q) + 1, NBANK));
            end

            case (state_q)
                W_IDLE:  if (wr_acc) state_d = W_FILL;
                W_FILL:  if (line_cmp && (avail_d == LW'(NBANK))) state_d = W_BLOCK;
                W_BLOCK: if (adv_ok) state_d = W_FILL;
                default: state_d = W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= W_IDLE;
            wr_addr_q   <= '0;
            oldest_q    <= '0;
            avail_q     <= '0;
            line_done_q <= 1'b0;
            ovf_q       <= 1'b0;
            rd_vld_q    <= 1'b0;
            data_ok_q   <= 1'b0;
            top_sel_q   <= '0;
            bot_sel_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            oldest_q    <= oldest_d;
            avail_q     <= avail_d;
            line_done_q <= line_done_d;
            ovf_q       <= ovf_d;
            rd_vld_q    <= rd_vld_d;
            data_ok_q   <= data_ok_d;
            top_sel_q   <= top_sel_d;
            bot_sel_q   <= bot_sel_d;
        end
    end

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        for (genvar c = 0; c < CH; c++) begin : g_ch
            bram_asymmetric_r2_w1_port #(
                .C_ADDR_WIDTH(AW),
                .C_DATA_WIDTH(DW)
            ) u_ram (
                .wclk   (clk_in),
                .we     (we_any && (we_bank == BW'(b))),
                .waddr  (we_addr),
                .wdata  (wr_data[c*DW +: DW]),
                .rclk   (clk_in),
                .re     (rd_acc),
                .raddr0 (rd_addr0),
                .raddr1 (rd_addr1),
                .rdata0 (bank_rd0[b][c*DW +: DW]),
                .rdata1 (bank_rd1[b][c*DW +: DW])
            );
        end
    end

    always_comb begin
        top0 = '0;
        top1 = '0;
        bot0 = '0;
        bot1 = '0;
        for (int b = 0; b < NBANK; b++) begin
            if (top_sel_q == BW'(b)) begin
                top0 = bank_rd0[b];
                top1 = bank_rd1[b];
            end
            if (bot_sel_q == BW'(b)) begin
                bot0 = bank_rd0[b];
                bot1 = bank_rd1[b];
            end
        end
    end

    // RAM output registers have no reset, so taps read as zero until the first fetch.
    assign rd_top0     = data_ok_q ? top0 : '0;
    assign rd_top1     = data_ok_q ? top1 : '0;
    assign rd_bot0     = data_ok_q ? bot0 : '0;
    assign rd_bot1     = data_ok_q ? bot1 : '0;
    assign rd_vld      = rd_vld_q;
    assign lines_avail = avail_q;
    assign line_done   = line_done_q;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_rgb_linebuf_pingpong.sv
// Scoreboard bench for rgb_linebuf_pingpong with a 4-pixel, 3-bank geometry.
module tb_rgb_linebuf_pingpong;
    import rgb_linebuf_pingpong_pkg::*;

    localparam int CH = 3, DW = 8, AW = 4, LINE_W = 4, NBANK = 3;
    localparam int PW = CH*DW;
    localparam int LW = $clog2(NBANK+1);

    logic          clk_in = 1'b0;
    logic          rst_n;
    logic          wr_sof, wr_vld, wr_rdy, rd_req, rd_line_adv, rd_vld, line_done, ovf;
    logic [PW-1:0] wr_data, rd_top0, rd_top1, rd_bot0, rd_bot1;
    logic [AW-1:0] rd_addr0, rd_addr1;
    logic [LW-1:0] lines_avail;

    typedef struct packed {
        logic [PW-1:0] t0;
        logic [PW-1:0] t1;
        logic [PW-1:0] b0;
        logic [PW-1:0] b1;
    } rd_exp_t;

    rd_exp_t exp_q[$];
    int n_chk = 0;
    int n_fail = 0;
    int ld_count = 0;

    rgb_linebuf_pingpong #(
        .CH(CH), .DW(DW), .AW(AW), .LINE_W(LINE_W), .NBANK(NBANK)
    ) dut (
        .clk_in(clk_in), .rst_n(rst_n), .wr_sof(wr_sof), .wr_vld(wr_vld),
        .wr_data(wr_data), .wr_rdy(wr_rdy), .rd_req(rd_req), .rd_addr0(rd_addr0),
        .rd_addr1(rd_addr1), .rd_line_adv(rd_line_adv), .rd_top0(rd_top0),
        .rd_top1(rd_top1), .rd_bot0(rd_bot0), .rd_bot1(rd_bot1), .rd_vld(rd_vld),
        .lines_avail(lines_avail), .line_done(line_done), .ovf(ovf)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: every rd_vld beat must match the oldest queued expectation.
    always @(negedge clk_in) begin
        if (rst_n && line_done) ld_count++;
        if (rst_n && rd_vld) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rd_unexpected: got rd_vld=1, expected 0");
            end else begin
                rd_exp_t e;
                e = exp_q.pop_front();
                check("rd_top0", 32'(rd_top0), 32'(e.t0));
                check("rd_top1", 32'(rd_top1), 32'(e.t1));
                check("rd_bot0", 32'(rd_bot0), 32'(e.b0));
                check("rd_bot1", 32'(rd_bot1), 32'(e.b1));
            end
        end
    end

    function automatic logic [PW-1:0] pix(input int n);
        return {8'(n+1), 8'(n+2), 8'(n+3)};
    endfunction

    task automatic wr(input logic [PW-1:0] d);
        wr_vld = 1'b1; wr_data = d;
        @(negedge clk_in);
        wr_vld = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_req = 1'b1; rd_addr0 = a0; rd_addr1 = a1;
        @(negedge clk_in);
        rd_req = 1'b0;
    endtask

    task automatic adv();
        rd_line_adv = 1'b1;
        @(negedge clk_in);
        rd_line_adv = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; wr_sof = 1'b0; wr_vld = 1'b0; wr_data = '0;
        rd_req = 1'b0; rd_addr0 = '0; rd_addr1 = '0; rd_line_adv = 1'b0;
        repeat (2) @(negedge clk_in);
        check("rst_lines_avail", 32'(lines_avail), 0);
        check("rst_rd_vld", 32'(rd_vld), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_line_done", 32'(line_done), 0);
        check("rst_rd_top0", 32'(rd_top0), 0);
        check("rst_wr_rdy", 32'(wr_rdy), 1);
        rst_n = 1'b1;
        @(negedge clk_in);

        // Two lines, then a tap read across them.
        for (int n = 0; n < 8; n++) wr(pix(n));
        @(negedge clk_in);
        check("two_lines_done_pulses", 32'(ld_count), 2);
        check("two_lines_avail", 32'(lines_avail), 2);
        exp_q.push_back('{t0: 24'h020304, t1: 24'h030405, b0: 24'h060708, b1: 24'h070809});
        rd(4'd1, 4'd2);
        @(negedge clk_in);
        check("rd_vld_single_beat", 32'(rd_vld), 0);
        check("rd_data_held", 32'(rd_top0), 32'h020304);

        // Fill the third bank: writer blocks, further pixels are dropped.
        for (int n = 8; n < 12; n++) wr(pix(n));
        check("full_lines_avail", 32'(lines_avail), 3);
        check("full_wr_rdy", 32'(wr_rdy), 0);
        check("full_state_block", 32'(dut.state_q), 32'(W_BLOCK));
        wr(24'hEEEEEE);
        check("drop_ovf", 32'(ovf), 1);
        exp_q.push_back('{t0: 24'h010203, t1: 24'h020304, b0: 24'h050607, b1: 24'h060708});
        rd(4'd0, 4'd1);
        adv();
        check("adv_wr_rdy", 32'(wr_rdy), 1);
        check("adv_lines_avail", 32'(lines_avail), 2);

        // Line completion coincident with a release.
        for (int n = 0; n < 3; n++) wr(24'h300000 + 24'(n));
        rd_line_adv = 1'b1;
        wr(24'h300003);
        rd_line_adv = 1'b0;
        check("coinc_line_done", 32'(line_done), 1);
        check("coinc_lines_avail", 32'(lines_avail), 2);
        exp_q.push_back('{t0: 24'h090A0B, t1: 24'h0C0D0E, b0: 24'h300000, b1: 24'h300003});
        rd(4'd0, 4'd3);

        // Read with one line refused; release with none ignored.
        adv();
        check("one_line_avail", 32'(lines_avail), 1);
        rd(4'd1, 4'd1);
        check("refused_rd_vld", 32'(rd_vld), 0);
        check("refused_data_held", 32'(rd_top0), 32'h090A0B);
        adv();
        adv();
        check("empty_adv_ignored", 32'(lines_avail), 0);

        // Frame start mid-line flushes everything; the coincident pixel lands at bank 0, addr 0.
        for (int n = 0; n < 10; n++) wr(24'h400000 + 24'(n));
        check("pre_sof_lines_avail", 32'(lines_avail), 2);
        check("pre_sof_ovf", 32'(ovf), 1);
        wr_sof = 1'b1;
        wr(24'hABCDEF);
        wr_sof = 1'b0;
        check("sof_lines_avail", 32'(lines_avail), 0);
        check("sof_ovf", 32'(ovf), 0);
        for (int n = 1; n < 4; n++) wr(24'h500000 + 24'(n));
        for (int n = 0; n < 4; n++) wr(24'h500010 + 24'(n));
        check("post_sof_lines_avail", 32'(lines_avail), 2);
        exp_q.push_back('{t0: 24'hABCDEF, t1: 24'h500001, b0: 24'h500010, b1: 24'h500011});
        rd(4'd0, 4'd1);

        // Reset during an outstanding read.
        rd_req = 1'b1; rd_addr0 = 4'd2; rd_addr1 = 4'd3;
        @(posedge clk_in);
        #2;
        rst_n = 1'b0;
        rd_req = 1'b0;
        #1;
        check("midrd_rst_rd_vld", 32'(rd_vld), 0);
        check("midrd_rst_lines_avail", 32'(lines_avail), 0);
        check("midrd_rst_rd_top0", 32'(rd_top0), 0);
        check("midrd_rst_ovf", 32'(ovf), 0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n = 1'b1;
        @(negedge clk_in);
        for (int n = 0; n < 8; n++) wr(24'h600000 + 24'(n));
        check("post_rst_lines_avail", 32'(lines_avail), 2);
        exp_q.push_back('{t0: 24'h600003, t1: 24'h600000, b0: 24'h600007, b1: 24'h600004});
        rd(4'd3, 4'd0);
        repeat (2) @(negedge clk_in);
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
